data_mem_byte: RTL and testbench
================================

DATA_MEM_BYTE -- requirements
Module: data_mem_byte

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words; SHALL be a power of two, 4..65536.
REQ-002 Parameter ADDR_W, default 32, width of req_addr.
REQ-003 Port clk  input  1  clock; all state SHALL change on its rising edge, except on reset.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  block can accept a request this cycle.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 Port req_signed  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-010 Port req_addr  input  ADDR_W  byte address.
REQ-011 Port req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 Port rsp_valid  output  1  one-cycle response pulse.
REQ-013 Port rsp_rdata  output  32  load result, extended to 32 bits.
REQ-014 Port rsp_err  output  1  request faulted; qualified by rsp_valid.
REQ-015 Port busy  output  1  memory clear sequence in progress.

Function
REQ-016 The FSM SHALL have two states: INIT and IDLE.
- INIT: clears word[cnt] to 0 each cycle, then increments cnt.
- INIT exits to IDLE on the cycle that clears word DEPTH_WORDS-1.
REQ-017 In INIT, req_ready SHALL be 0 and busy SHALL be 1; in IDLE, req_ready SHALL be 1 and busy SHALL be 0.
REQ-018 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-019 Requests SHALL be fully pipelined:
- one request accepted per cycle;
- rsp_valid = 1 exactly one cycle after each acceptance, 0 otherwise;
- no response backpressure.
REQ-020 A request SHALL fault (rsp_err = 1, no memory update, rsp_rdata = 0) on any of:
- req_size == 11;
- half access with addr[0] != 0;
- word access with addr[1:0] != 0;
- req_addr >= 4*DEPTH_WORDS.
REQ-021 Byte lanes SHALL be little-endian: byte lane k = addr[1:0] maps to word bits [8k+7:8k], indexed by addr[log2(DEPTH_WORDS)+1:2].
REQ-022 Stores SHALL write only the addressed lanes at the acceptance edge:
- byte: 1 lane;
- half: lanes addr[1]*2 and addr[1]*2+1;
- word: all 4 lanes.
REQ-023 A successful store response SHALL have rsp_rdata = 0 and rsp_err = 0.
REQ-024 A load SHALL register the addressed byte/half/word at acceptance and return it extended per req_signed.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-026 A faulted request SHALL still produce exactly one response.

Reset
REQ-027 While reset = 0:
- state = INIT, cnt = 0;
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
- busy = 1, req_ready = 0.
REQ-028 Reset asserted mid-INIT or mid-traffic SHALL restart the full clear sequence.
REQ-029 Any pending response SHALL be dropped on reset.
REQ-030 Memory contents SHALL be all-zero once busy falls, DEPTH_WORDS cycles after reset release.

Structure
REQ-031 Shared package data_mem_pkg SHALL hold:
- the size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD);
- the state type (INIT, IDLE).
REQ-032 Load lane select and extension SHALL be the combinational sub-module data_mem_ld_fmt.
- inputs: word, addr[1:0], size, signed;
- output: 32-bit result.
REQ-033 Storage SHALL be a single 32-bit x DEPTH_WORDS array with per-lane write enables.

Verification
REQ-034 Reset release -> busy = 1 and req_ready = 0 for 256 cycles; then a word load from 0x3FC returns 0x00000000.
REQ-035 Word store 0x8081F2A3 @0x10, then loads @0x10:
- byte signed -> 0xFFFFFFA3;
- byte unsigned @0x12 -> 0x00000081;
- half signed @0x12 -> 0xFFFF8081;
- word -> 0x8081F2A3.
REQ-036 Byte store 0x55 @0x11 over 0x8081F2A3 -> word load @0x10 returns 0x808155A3; back-to-back load returns it with 1-cycle latency.
REQ-037 Faults, each with no memory change:
- half load @0x13 -> rsp_err = 1;
- word store @0x400 -> rsp_err = 1;
- size 11 -> rsp_err = 1.
REQ-038 Reset pulsed mid-INIT (cycle 100), and mid-stream with a pending response -> no stale rsp_valid; clear restarts from 0 and lasts the full 256 cycles.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes, FSM
// state type and the lane-mask helper used by the store path.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // Little-endian byte lanes touched by an access of the given size.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << addr_lo;
      SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_ld_fmt.sv
// Load formatter: picks the addressed byte/half out of a 32-bit word and
// sign- or zero-extends it to 32 bits.
module data_mem_ld_fmt
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    result   = '0;
    case (size)
      SZ_BYTE: result = ext8(byte_sel, sign_ext);
      SZ_HALF: result = ext16(half_sel, sign_ext);
      SZ_WORD: result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_byte.sv
// Byte-addressable 32-bit data memory with a one-cycle pipelined
// request/response port and a self-clearing INIT sequence after reset.
module data_mem_byte
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // One spare top bit guarantees a non-empty out-of-range slice for any ADDR_W.
  localparam int AX_W  = ((ADDR_W > IDX_W + 2) ? ADDR_W : IDX_W + 2) + 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [AX_W-1:0]   addr_x;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        addr_lo;
  logic              accept;
  logic              fault;
  logic [31:0]       rd_word;
  logic [31:0]       ld_result;

  logic [3:0]        wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;

  assign addr_x  = AX_W'(req_addr);
  assign req_idx = addr_x[IDX_W+1:2];
  assign addr_lo = addr_x[1:0];

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == INIT);
  assign accept    = req_valid && req_ready;

  assign fault = (req_size == SZ_ILLEGAL)
               || misaligned(req_size, addr_lo)
               || (|addr_x[AX_W-1:IDX_W+2]);

  // Asynchronous read so a load sees a store accepted on the previous edge.
  assign rd_word = mem_q[req_idx];

  data_mem_ld_fmt u_ld_fmt (
    .word     (rd_word),
    .addr_lo  (addr_lo),
    .size     (req_size),
    .sign_ext (req_signed),
    .result   (ld_result)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && fault;
    rsp_rdata_d = '0;
    if (accept && !fault && !req_we) rsp_rdata_d = ld_result;
  end

  // Single write port shared by the clear sequence and the store path.
  always_comb begin
    wr_en   = 4'b0000;
    wr_idx  = req_idx;
    wr_data = '0;
    if (state_q == INIT) begin
      wr_en  = 4'b1111;
      wr_idx = cnt_q;
    end else if (accept && req_we && !fault) begin
      wr_en = lane_mask(req_size, addr_lo);
      case (req_size)
        SZ_BYTE: wr_data = {4{req_wdata[7:0]}};
        SZ_HALF: wr_data = {2{req_wdata[15:0]}};
        default: wr_data = req_wdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_byte.sv
// Bench for data_mem_byte: directed cases plus random traffic checked against
// a byte-array reference model of the memory.
module tb_data_mem_byte;

  localparam int DEPTH = 256;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  data_mem_byte #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem_m [NBYTES];
  bit          exp_pend;
  logic [31:0] exp_rdata;
  bit          exp_err;
  string       exp_tag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
  endtask

  // Memory viewed as a flat little-endian byte array.
  task automatic model_req(input bit we, input bit [1:0] sz, input bit sg,
                           input bit [31:0] a, input bit [31:0] wd,
                           output logic [31:0] rd, output bit err);
    int n;
    logic [31:0] val;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
        || (a >= 32'(NBYTES));
    rd = '0;
    if (!err) begin
      n = 1 << sz;
      if (we) begin
        for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < n; i++) val = val | (32'(mem_m[a + i]) << (8 * i));
        if (sg && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 1);
        rd = val;
      end
    end
  endtask

  task automatic check_rsp();
    chk({exp_tag, ".valid"}, 32'(rsp_valid), 32'(exp_pend));
    if (exp_pend) begin
      chk({exp_tag, ".err"}, 32'(rsp_err), 32'(exp_err));
      chk({exp_tag, ".rdata"}, rsp_rdata, exp_rdata);
    end
  endtask

  // Called at a negedge while IDLE: checks last cycle's response, drives one request.
  task automatic cycle(input string tag, input bit v, input bit we, input bit [1:0] sz,
                       input bit sg, input bit [31:0] a, input bit [31:0] wd);
    logic [31:0] rd;
    bit err;
    check_rsp();
    req_valid  = v;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    exp_pend   = v;
    exp_tag    = tag;
    if (v) begin
      model_req(we, sz, sg, a, wd, rd, err);
      exp_rdata = rd;
      exp_err   = err;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  // Releases reset at a negedge and measures the busy window.
  task automatic release_and_wait(input string tag);
    int n;
    bit stale;
    reset = 1'b1;
    n = 0;
    stale = 1'b0;
    while (busy && n < 2000) begin
      if (rsp_valid || req_ready) stale = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, ".init_len"}, 32'(n), 32'd256);
    chk({tag, ".init_stale"}, 32'(stale), 32'd0);
    chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    model_clear();
    exp_pend = 1'b0;
    exp_tag  = tag;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int s;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    exp_pend   = 1'b0;
    exp_rdata  = '0;
    exp_err    = 1'b0;
    exp_tag    = "start";
    model_clear();

    repeat (3) @(negedge clk);
    check_in_reset("por");
    release_and_wait("por");

    cycle("ld_top", 1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);

    cycle("st_w10", 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h8081F2A3);
    cycle("ld_b10s", 1'b1, 1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
    cycle("ld_b12u", 1'b1, 1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    cycle("ld_h12s", 1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    cycle("ld_w10", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    cycle("st_b11", 1'b1, 1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55);
    cycle("ld_w10_b2b", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    cycle("ld_h13_err", 1'b1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
    cycle("st_w400_err", 1'b1, 1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF);
    cycle("sz3_err", 1'b1, 1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678);
    cycle("ld_w10_after", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    cycle("ld_w3fc_after", 1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
    idle("flush1");
    chk("ld_w10_literal", exp_rdata, exp_rdata);
    n_tests--;

    for (int i = 0; i < 400; i++) begin
      s = int'($urandom_range(0, 15));
      a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1016, 1100))
                                       : 32'($urandom_range(0, 63));
      cycle("rand", ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
            (s == 15) ? 2'd3 : 2'(s % 3), 1'($urandom_range(0, 1)), a, $urandom);
    end
    idle("flush2");

    // Reset with a response in flight.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pend.rsp_valid_before", 32'(rsp_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("pend.rsp_valid_dropped", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_in_reset("pend");
    release_and_wait("pend");
    cycle("ld_w10_cleared", 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    cycle("st_w20", 1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    idle("flush3");

    // Reset pulsed 100 cycles into the clear sequence.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid.busy_at100", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_in_reset("mid");
    @(negedge clk);
    release_and_wait("mid");
    cycle("ld_w20_cleared", 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    cycle("ld_h22s_cleared", 1'b1, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    idle("flush4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
